pe_mac_stream: RTL and testbench

//  Parametrised streaming multiply-accumulate processing element; next generation of the scalar PE.

---
 rtl/pe_pkg.sv | 34 +++
 rtl/pe_mult_stage.sv | 65 ++++++
 rtl/pe_mac_stream.sv | 153 +++++++++++++++
 tb/tb_pe_mac_stream.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and helpers for the streaming MAC processing element.
// Provides the run-tracking FSM state type and the accumulator clamp limits
// used when the design is built with PE_SAT_EN defined.
package pe_pkg;

  typedef enum logic {
    PE_IDLE  = 1'b0,
    PE_ACCUM = 1'b1
  } pe_state_e;

  // Widest accumulator the limit helpers can describe.
  localparam int MAX_ACC_W = 128;

  // Largest representable accumulator value for width w.
  function automatic logic [MAX_ACC_W-1:0] acc_max(input int w, input bit sgn);
    logic [MAX_ACC_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_ACC_W; i++) begin
      if (i < (sgn ? w - 1 : w)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Smallest representable accumulator value for width w (zero when unsigned).
  function automatic logic [MAX_ACC_W-1:0] acc_min(input int w, input bit sgn);
    logic [MAX_ACC_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_ACC_W; i++) begin
      if (sgn && (i == w - 1)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pe_mult_stage.sv
// Stage 1 of the MAC PE: registered multiplier plus first/last flag pipe.
// The product is extended to the accumulator width (sign- or zero-extended
// per SIGNED). The stage holds its contents while stage 2 is stalled.
module pe_mult_stage
  import pe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              stall,
  input  logic              accept,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              first,
  input  logic              last,
  output logic              p_valid,
  output logic [ACC_W-1:0]  p_q,
  output logic              p_first,
  output logic              p_last
);

  localparam bit SGN   = (SIGNED != 0);
  localparam int PW    = 2 * DATA_W;
  localparam int EXT_W = ACC_W - PW;

  logic [PW-1:0]    a_ext, b_ext, prod;
  logic [ACC_W-1:0] prod_ext;

  // Extending both operands to the full product width lets one unsigned
  // multiplier produce the correct low bits for either signedness.
  assign a_ext = {{DATA_W{SGN & a[DATA_W-1]}}, a};
  assign b_ext = {{DATA_W{SGN & b[DATA_W-1]}}, b};
  assign prod  = a_ext * b_ext;

  if (EXT_W > 0) begin : g_ext
    assign prod_ext = {{EXT_W{SGN & prod[PW-1]}}, prod};
  end else begin : g_noext
    assign prod_ext = prod[ACC_W-1:0];
  end

  // Product/flag register: flush on clr, hold on stall, else load accepted pair.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
      p_q     <= '0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
    end else if (clr) begin
      p_valid <= 1'b0;
    end else if (!stall) begin
      p_valid <= accept;
      if (accept) begin
        p_q     <= prod_ext;
        p_first <= first;
        p_last  <= last;
      end
    end
  end

endmodule

// File: rtl/pe_mac_stream.sv
// Streaming multiply-accumulate PE: operand pairs in over valid/ready,
// registered multiply, run accumulation delimited by first/last, and a held
// result output with backpressure.
// Optional feature macro: PE_SAT_EN (saturating accumulate + sticky out_ovf).
module pe_mac_stream
  import pe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_first,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf
);

  if (ACC_W < 2 * DATA_W) begin : g_width_check
    $error("pe_mac_stream: ACC_W must be at least 2*DATA_W");
  end

  logic             p_valid, p_first, p_last;
  logic [ACC_W-1:0] p_q, acc, sum;
  logic             stall, accept, consume, start;
  pe_state_e        state, state_d;

  // A finished sum can only leave stage 2 when the output slot is free.
  assign stall    = p_valid & p_last & out_valid & ~out_ready;
  assign in_ready = ~stall & ~clr;
  assign accept   = in_valid & in_ready;
  assign consume  = p_valid & ~stall & ~clr;
  // A pair opens a new run when flagged first or when no run is open.
  assign start    = p_first | (state == PE_IDLE);

  pe_mult_stage #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W),
    .SIGNED(SIGNED)
  ) u_mult (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .stall  (stall),
    .accept (accept),
    .a      (in_a),
    .b      (in_b),
    .first  (in_first),
    .last   (in_last),
    .p_valid(p_valid),
    .p_q    (p_q),
    .p_first(p_first),
    .p_last (p_last)
  );

`ifdef PE_SAT_EN
  localparam bit                 SGN      = (SIGNED != 0);
  localparam logic [MAX_ACC_W-1:0] MAX_FULL = acc_max(ACC_W, SGN);
  localparam logic [MAX_ACC_W-1:0] MIN_FULL = acc_min(ACC_W, SGN);
  localparam logic [ACC_W-1:0]   ACC_MAX  = MAX_FULL[ACC_W-1:0];
  localparam logic [ACC_W-1:0]   ACC_MIN  = MIN_FULL[ACC_W-1:0];

  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   raw;
  logic             clamp_hi, clamp_lo, ovf_q, run_ovf;

  // Saturating add: detect overflow of the chosen number format and clamp.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    base = start ? '0 : acc;
    raw  = {1'b0, base} + {1'b0, p_q};
    if (SGN) begin
      clamp_hi = ~base[ACC_W-1] & ~p_q[ACC_W-1] &  raw[ACC_W-1];
      clamp_lo =  base[ACC_W-1] &  p_q[ACC_W-1] & ~raw[ACC_W-1];
    end else begin
      clamp_hi = raw[ACC_W];
      clamp_lo = 1'b0;
    end
    sum     = clamp_hi ? ACC_MAX : (clamp_lo ? ACC_MIN : raw[ACC_W-1:0]);
    run_ovf = (~start & ovf_q) | clamp_hi | clamp_lo;
  end
`else
  // Wrap-around add modulo 2^ACC_W.
  always_comb begin
    sum = start ? p_q : (acc + p_q);
  end

  assign out_ovf = 1'b0;
`endif

  // Run FSM next state: a consumed last pair closes the run, any other opens/keeps it.
  always_comb begin
    state_d = state;
    if (clr) begin
      state_d = PE_IDLE;
    end else if (consume) begin
      state_d = p_last ? PE_IDLE : PE_ACCUM;
    end
  end

  // Run FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PE_IDLE;
    else        state <= state_d;
  end

  // Accumulator and held result: retire on handshake, reload on a consumed last pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_acc   <= '0;
`ifdef PE_SAT_EN
      ovf_q     <= 1'b0;
      out_ovf   <= 1'b0;
`endif
    end else if (clr) begin
      acc       <= '0;
      out_valid <= 1'b0;
`ifdef PE_SAT_EN
      ovf_q     <= 1'b0;
      out_ovf   <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (consume) begin
        if (p_last) begin
          out_acc   <= sum;
          out_valid <= 1'b1;
          acc       <= '0;
`ifdef PE_SAT_EN
          out_ovf   <= run_ovf;
          ovf_q     <= 1'b0;
`endif
        end else begin
          acc       <= sum;
`ifdef PE_SAT_EN
          ovf_q     <= run_ovf;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_stream.sv
// Self-checking bench for pe_mac_stream (DATA_W=16, ACC_W=32, SIGNED=1).
// Accepted pairs feed a run-level reference model that pushes expected sums
// into a queue; an independent monitor pops and compares on each output
// handshake and checks that a held result stays stable.
module tb_pe_mac_stream;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam longint MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (ACC_W - 1));

  logic              clk = 1'b0;
  logic              rst_n, clr;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_a, in_b;
  logic              in_first, in_last;
  logic              out_valid, out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic              out_ovf;

  pe_mac_stream #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W),
    .SIGNED(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_first (in_first),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_acc  (out_acc),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic             ovf;
  } exp_t;

  exp_t   exp_q[$];
  int     total = 0;
  int     bad   = 0;
  bit     rand_ready = 1'b0;
  bit     ready_force = 1'b1;
  bit     run_open = 1'b0;
  longint run_acc = 0;
  bit     run_ovf = 1'b0;
  bit     prev_hold = 1'b0;
  logic [ACC_W-1:0] prev_acc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: signed products summed per run, wrapped or clamped at ACC_W.
  task automatic model_pair(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                            input bit first, input bit last);
    longint p;
    exp_t   e;
    p = longint'($signed(a)) * longint'($signed(b));
    if (first || !run_open) begin
      run_acc = p;
      run_ovf = 1'b0;
    end else begin
      run_acc = run_acc + p;
`ifdef PE_SAT_EN
      if (run_acc > MAXV) begin run_acc = MAXV; run_ovf = 1'b1; end
      if (run_acc < MINV) begin run_acc = MINV; run_ovf = 1'b1; end
`endif
    end
    run_open = !last;
    if (last) begin
      e.acc = run_acc[ACC_W-1:0];
      e.ovf = run_ovf;
      exp_q.push_back(e);
    end
  endtask

  task automatic model_flush();
    run_open = 1'b0;
    exp_q.delete();
  endtask

  // out_ready: fixed level or random (mostly ready), updated just after each edge.
  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Monitor: compare each handshaken result, and check held results stay put.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && !clr) begin
      if (prev_hold) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_acc", 64'(out_acc), 64'(prev_acc));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("res_acc", 64'(out_acc), 64'(e.acc));
          check("res_ovf", 64'(out_ovf), 64'(e.ovf));
        end
      end
    end
    prev_hold = rst_n && !clr && out_valid && !out_ready;
    prev_acc  = out_acc;
  end

  // Present a pair until accepted; called and returns just after a rising edge.
  task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input bit first, input bit last);
    bit rdy;
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_first = first;
    in_last  = last;
    for (int k = 0; k < 500 && !done; k++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        model_pair(a, b, first, last);
        done = 1'b1;
      end
    end
    check("send_accept_timeout", 64'(done), 64'd1);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
    end
    check(name, 64'(found), 64'd1);
  endtask

  function automatic logic [DATA_W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return DATA_W'($urandom);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_acc", 64'(out_acc), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // 1: four-pair run, 70, result two edges after the last pair is presented.
    send(16'd1, 16'd5, 1, 0);
    send(16'd2, 16'd6, 0, 0);
    send(16'd3, 16'd7, 0, 0);
    send(16'd4, 16'd8, 0, 1);
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_not_yet", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_sum", 64'(out_acc), 64'd70);
    @(posedge clk); #1;
    idle(2);

    // 2: signed single-pair run, -3*7 sign-extended.
    send(16'hFFFD, 16'd7, 1, 1);
    in_valid = 1'b0;
    wait_valid("t2_timeout");
    check("t2_sum", 64'(out_acc), 64'hFFFF_FFEB);
    @(posedge clk); #1;
    idle(3);

    // 3: backpressure, second last pair stalls while 70 is held.
    ready_force = 1'b0;
    idle(2);
    send(16'd1, 16'd5, 1, 0);
    send(16'd2, 16'd6, 0, 0);
    send(16'd3, 16'd7, 0, 0);
    send(16'd4, 16'd8, 0, 1);
    send(16'd1, 16'd1, 1, 1);
    in_valid = 1'b0;
    @(negedge clk);
    check("t3_stall_rdy", 64'(in_ready), 64'd0);
    check("t3_held_valid", 64'(out_valid), 64'd1);
    check("t3_held_acc", 64'(out_acc), 64'd70);
    @(posedge clk); #1;
    idle(3);
    @(negedge clk);
    check("t3_still_stall", 64'(in_ready), 64'd0);
    check("t3_still_acc", 64'(out_acc), 64'd70);
    @(posedge clk); #1;
    ready_force = 1'b1;
    idle(6);
    check("t3_drained", 64'(exp_q.size()), 64'd0);

    // 4: 3 x 0x7FFF*0x7FFF at ACC_W=32.
    send(16'h7FFF, 16'h7FFF, 1, 0);
    send(16'h7FFF, 16'h7FFF, 0, 0);
    send(16'h7FFF, 16'h7FFF, 0, 1);
    in_valid = 1'b0;
    wait_valid("t4_timeout");
`ifdef PE_SAT_EN
    check("t4_sum", 64'(out_acc), 64'h7FFF_FFFF);
    check("t4_ovf", 64'(out_ovf), 64'd1);
`else
    check("t4_sum", 64'(out_acc), 64'hBFFD_0003);
    check("t4_ovf", 64'(out_ovf), 64'd0);
`endif
    @(posedge clk); #1;
    idle(3);

    // 5: reset after two pairs of a run; next run {2*3 last} without first.
    send(16'd1, 16'd1, 1, 0);
    send(16'd1, 16'd2, 0, 0);
    rst_n = 1'b0;
    in_valid = 1'b0;
    model_flush();
    @(negedge clk);
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_out_acc", 64'(out_acc), 64'd0);
    check("t5_out_ovf", 64'(out_ovf), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t5_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    send(16'd2, 16'd3, 0, 1);
    in_valid = 1'b0;
    wait_valid("t5_timeout");
    check("t5_sum", 64'(out_acc), 64'd6);
    @(posedge clk); #1;
    idle(3);

    // 6: clr drops the pair offered with it and the open partial sum.
    send(16'd1, 16'd1, 1, 0);
    send(16'd2, 16'd2, 0, 0);
    idle(2);
    clr = 1'b1;
    in_valid = 1'b1; in_a = 16'd9; in_b = 16'd9; in_first = 1'b0; in_last = 1'b1;
    @(negedge clk);
    check("t6_clr_rdy", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    in_valid = 1'b0;
    model_flush();
    @(negedge clk);
    check("t6_clr_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    send(16'd3, 16'd3, 0, 0);
    send(16'd4, 16'd4, 0, 1);
    in_valid = 1'b0;
    wait_valid("t6_timeout");
    check("t6_sum", 64'(out_acc), 64'd25);
    @(posedge clk); #1;
    idle(3);

    // Random runs with random backpressure and gaps.
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send(pick(), pick(), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    send(pick(), pick(), 0, 1);
    rand_ready = 1'b0;
    ready_force = 1'b1;
    idle(12);
    check("final_drain", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
